// File: rtl/swath_sequencer_if.sv
// Swath sequencer bus: table write port, sequence control,
// print-engine handshake and per-swath parameter outputs.
interface swath_sequencer_if;
  logic        tbl_wr;
  logic [2:0]  tbl_addr;
  logic [1:0]  tbl_field;
  logic [31:0] tbl_wdata;
  logic        seq_go;
  logic        seq_abort;
  logic [3:0]  num_swaths;
  logic [31:0] gap_reg;
  logic        print_active;
  logic        jet_enable;
  logic        start_pulse;
  logic [31:0] length_reg;
  logic [31:0] divider_reg;
  logic [31:0] delay_reg;
  logic [15:0] adjust_column;
  logic        seq_busy;
  logic [2:0]  swath_index;
  logic        swath_done;
  logic        seq_done;
  logic        seq_aborted;
  logic        timeout_err;

  modport master (
    output tbl_wr, tbl_addr, tbl_field, tbl_wdata,
    output seq_go, seq_abort, num_swaths, gap_reg,
    output print_active,
    input  jet_enable, start_pulse,
    input  length_reg, divider_reg, delay_reg,
    input  adjust_column, seq_busy, swath_index,
    input  swath_done, seq_done, seq_aborted,
    input  timeout_err
  );

  modport slave (
    input  tbl_wr, tbl_addr, tbl_field, tbl_wdata,
    input  seq_go, seq_abort, num_swaths, gap_reg,
    input  print_active,
    output jet_enable, start_pulse,
    output length_reg, divider_reg, delay_reg,
    output adjust_column, seq_busy, swath_index,
    output swath_done, seq_done, seq_aborted,
    output timeout_err
  );
endinterface

// File: rtl/swath_sequencer.sv
// Swath sequencer: 8-entry swath table driving an arm/start/run/gap FSM.
// Define SWATH_TIMEOUT_EN to compile in the WAIT_ACT watchdog (ERR state).
module swath_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4800,
  parameter int unsigned ARM_CYCLES     = 2
) (
  input logic              clk48mhz,
  input logic              rst,
  swath_sequencer_if.slave bus
);

`ifdef SWATH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, LOAD, ARM, START, WAIT_ACT, RUN, GAP, ERR
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] cnt_inc;
  logic [2:0]  idx;
  logic [2:0]  last;
  logic        jet_q;
  logic        sp_q;
  logic        busy_q;
  logic        sd_q;
  logic        qd_q;
  logic        ab_q;
  logic        terr_q;
  logic [31:0] len_q;
  logic [31:0] div_q;
  logic [31:0] dly_q;
  logic [15:0] adj_q;

  logic [31:0] t_len [8];
  logic [31:0] t_div [8];
  logic [31:0] t_dly [8];
  logic [15:0] t_adj [8];
  logic        wr_ok;

  // the entry being played out is frozen while the sequence runs
  assign wr_ok = bus.tbl_wr &&
                 !(busy_q && bus.tbl_addr == idx);

  always_ff @(posedge clk48mhz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        t_len[i] <= '0;
        t_div[i] <= '0;
        t_dly[i] <= '0;
        t_adj[i] <= '0;
      end
    end else if (wr_ok) begin
      unique case (bus.tbl_field)
        2'd0: t_len[bus.tbl_addr] <= bus.tbl_wdata;
        2'd1: t_div[bus.tbl_addr] <= bus.tbl_wdata;
        2'd2: t_dly[bus.tbl_addr] <= bus.tbl_wdata;
        2'd3: t_adj[bus.tbl_addr] <= bus.tbl_wdata[15:0];
      endcase
    end
  end

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 32'd1;

  always_ff @(posedge clk48mhz or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      last   <= '0;
      jet_q  <= 1'b0;
      sp_q   <= 1'b0;
      busy_q <= 1'b0;
      sd_q   <= 1'b0;
      qd_q   <= 1'b0;
      ab_q   <= 1'b0;
      terr_q <= 1'b0;
      len_q  <= '0;
      div_q  <= '0;
      dly_q  <= '0;
      adj_q  <= '0;
    end else begin
      sp_q <= 1'b0;
      sd_q <= 1'b0;
      qd_q <= 1'b0;
      ab_q <= 1'b0;
      if (bus.seq_abort && state != IDLE) begin
        state  <= IDLE;
        cnt    <= '0;
        jet_q  <= 1'b0;
        busy_q <= 1'b0;
        ab_q   <= 1'b1;
      end else begin
        unique case (state)
          IDLE, ERR: begin
            if (bus.seq_go && !bus.seq_abort) begin
              terr_q <= 1'b0;
              if (bus.num_swaths == 4'd0) begin
                qd_q  <= 1'b1;
                state <= IDLE;
              end else begin
                state  <= LOAD;
                idx    <= '0;
                busy_q <= 1'b1;
                last   <= (bus.num_swaths > 4'd8) ? 3'd7
                        : 3'(bus.num_swaths - 4'd1);
              end
            end
          end
          LOAD: begin
            len_q <= t_len[idx];
            div_q <= t_div[idx];
            dly_q <= t_dly[idx];
            adj_q <= t_adj[idx];
            jet_q <= 1'b1;
            cnt   <= '0;
            state <= ARM;
          end
          ARM: begin
            if ({1'b0, cnt} + 33'd1 >= 33'(ARM_CYCLES)) begin
              sp_q  <= 1'b1;
              cnt   <= '0;
              state <= START;
            end else begin
              cnt <= cnt_inc;
            end
          end
          START: begin
            cnt   <= cnt_inc;
            state <= WAIT_ACT;
          end
          // cnt holds cycles elapsed since start_pulse
          WAIT_ACT: begin
            if (bus.print_active) begin
              cnt   <= '0;
              state <= RUN;
            end else if (TO_EN &&
                {1'b0, cnt} + 33'd1 >= 33'(TIMEOUT_CYCLES)) begin
              jet_q  <= 1'b0;
              busy_q <= 1'b0;
              terr_q <= 1'b1;
              state  <= ERR;
            end else begin
              cnt <= cnt_inc;
            end
          end
          RUN: begin
            if (!bus.print_active) begin
              sd_q  <= 1'b1;
              jet_q <= 1'b0;
              cnt   <= '0;
              if (idx == last) begin
                qd_q   <= 1'b1;
                busy_q <= 1'b0;
                state  <= IDLE;
              end else begin
                state <= GAP;
              end
            end
          end
          GAP: begin
            if (cnt >= bus.gap_reg) begin
              idx   <= idx + 3'd1;
              state <= LOAD;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.jet_enable    = jet_q;
  assign bus.start_pulse   = sp_q;
  assign bus.length_reg    = len_q;
  assign bus.divider_reg   = div_q;
  assign bus.delay_reg     = dly_q;
  assign bus.adjust_column = adj_q;
  assign bus.seq_busy      = busy_q;
  assign bus.swath_index   = idx;
  assign bus.swath_done    = sd_q;
  assign bus.seq_done      = qd_q;
  assign bus.seq_aborted   = ab_q;
  assign bus.timeout_err   = TO_EN ? terr_q : 1'b0;

endmodule

// File: tb/tb_swath_sequencer.sv
// Bench for swath_sequencer: per-swath event times are derived
// arithmetically from the sequence parameters and checked every cycle.
module tb_swath_sequencer;
  localparam int A  = 2;
  localparam int TO = 16;

  logic clk48mhz = 1'b0;
  logic rst = 1'b1;
  always #10 clk48mhz = ~clk48mhz;

  swath_sequencer_if bus();

  swath_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .ARM_CYCLES(A)
  ) dut (
    .clk48mhz(clk48mhz),
    .rst(rst),
    .bus(bus)
  );

  int vecs = 0;
  int errs = 0;

  logic [31:0] m_len [8];
  logic [31:0] m_div [8];
  logic [31:0] m_dly [8];
  logic [15:0] m_adj [8];

  int nn, sd_d, sd_r, sd_g, done_t;
  int ls [8];
  int ss [8];
  int n_start, n_sdone, n_qdone, min_gap;

  typedef struct {
    int n; int g; int d; int r;
    int e_start; int e_sdone; int e_qdone;
  } row_t;
  row_t rows [6];

  task automatic step();
    @(posedge clk48mhz);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] obs_flags();
    return {bus.jet_enable, bus.start_pulse, bus.swath_done,
            bus.seq_done, bus.seq_busy, bus.seq_aborted,
            bus.timeout_err};
  endfunction

  function automatic logic [127:0] obs_regs();
    return {16'h0, bus.length_reg, bus.divider_reg,
            bus.delay_reg, bus.adjust_column};
  endfunction

  function automatic logic [127:0] exp_regs(input int k);
    return {16'h0, m_len[k], m_div[k], m_dly[k], m_adj[k]};
  endfunction

  // swath k: LOAD at ls[k], start_pulse at ss[k], done at ss[k]+d+r+1
  task automatic plan(input int n, input int g, input int d,
                      input int r);
    nn = (n > 8) ? 8 : n;
    sd_g = g; sd_d = d; sd_r = r;
    ls[0] = 0;
    for (int k = 0; k < nn; k++) begin
      ss[k] = ls[k] + A + 1;
      if (k < 7) ls[k+1] = ss[k] + d + r + g + 2;
    end
    done_t = (nn == 0) ? 0 : ss[nn-1] + d + r + 1;
  endtask

  function automatic logic [6:0] exp_flags(input int t);
    logic j, s, w, q, b;
    j = 0; s = 0; w = 0;
    for (int k = 0; k < nn; k++) begin
      if (ss[k] == t) s = 1;
      if (ss[k] + sd_d + sd_r + 1 == t) w = 1;
      if (t >= ls[k] + 1 && t <= ss[k] + sd_d + sd_r) j = 1;
    end
    q = (t == done_t);
    b = (nn > 0 && t < done_t);
    return {j, s, w, q, b, 2'b00};
  endfunction

  function automatic int exp_idx(input int t);
    int ix;
    ix = 0;
    for (int k = 0; k < nn; k++)
      if (ls[k] <= t) ix = k;
    return ix;
  endfunction

  function automatic logic pa_at(input int t);
    logic p;
    p = 0;
    for (int k = 0; k < nn; k++)
      if (t >= ss[k] + sd_d && t <= ss[k] + sd_d + sd_r - 1) p = 1;
    return p;
  endfunction

  task automatic tbl_write(input int a, input int f,
                           input logic [31:0] d);
    logic [2:0] a3;
    logic [1:0] f2;
    a3 = a[2:0];
    f2 = f[1:0];
    step();
    bus.tbl_wr = 1; bus.tbl_addr = a3;
    bus.tbl_field = f2; bus.tbl_wdata = d;
    case (f2)
      2'd0: m_len[a3] = d;
      2'd1: m_div[a3] = d;
      2'd2: m_dly[a3] = d;
      default: m_adj[a3] = d[15:0];
    endcase
    step();
    bus.tbl_wr = 0;
  endtask

  task automatic run_seq(input int n, input int g, input int d,
                         input int r, input int abort_t,
                         input int wr_t, input int wa, input int wf,
                         input logic [31:0] wd);
    int t_end, low_cnt, k;
    bit low_run;
    logic live;
    logic [6:0] ef;
    logic [2:0] a3;
    plan(n, g, d, r);
    t_end = (abort_t >= 0) ? abort_t + 25 : done_t + 3;
    n_start = 0; n_sdone = 0; n_qdone = 0;
    min_gap = 1 << 30; low_cnt = 0; low_run = 0;
    step();
    bus.seq_go = 1; bus.num_swaths = n[3:0];
    bus.gap_reg = g; bus.print_active = 0;
    for (int t = 0; t <= t_end; t++) begin
      step();
      live = (abort_t < 0 || t <= abort_t);
      bus.seq_go = (t < done_t && live &&
                    $urandom_range(0, 19) == 0);
      bus.num_swaths = 4'($urandom_range(0, 15));
      bus.seq_abort = (t == abort_t);
      bus.print_active = live ? pa_at(t) : 1'b0;
      if (!live) ef = (t == abort_t + 1) ? 7'b0000010 : 7'b0;
      else ef = exp_flags(t);
      bus.tbl_wr = 0;
      if (t == wr_t) begin
        a3 = wa[2:0];
        bus.tbl_wr = 1; bus.tbl_addr = a3;
        bus.tbl_field = wf[1:0]; bus.tbl_wdata = wd;
        if (!(ef[2] && wa == exp_idx(t))) begin
          case (wf)
            0: m_len[a3] = wd;
            1: m_div[a3] = wd;
            2: m_dly[a3] = wd;
            default: m_adj[a3] = wd[15:0];
          endcase
        end
      end
      chk($sformatf("flags t=%0d", t), 128'(obs_flags()), 128'(ef));
      if (nn > 0 && live)
        chk($sformatf("index t=%0d", t), 128'(bus.swath_index),
            128'(exp_idx(t)));
      if (ef[5]) begin
        k = exp_idx(t);
        chk($sformatf("regs swath %0d", k), obs_regs(), exp_regs(k));
      end
      n_start += int'(bus.start_pulse);
      n_sdone += int'(bus.swath_done);
      n_qdone += int'(bus.seq_done);
      if (bus.seq_busy && !bus.jet_enable) begin
        if (low_run) low_cnt++;
      end else if (bus.jet_enable) begin
        if (low_run && low_cnt > 0 && low_cnt < min_gap)
          min_gap = low_cnt;
        low_run = 1; low_cnt = 0;
      end
    end
    bus.seq_go = 0; bus.seq_abort = 0;
    bus.print_active = 0; bus.tbl_wr = 0;
  endtask

  initial begin
    int ab, n, g, d, r, wt;
    bus.tbl_wr = 0; bus.tbl_addr = 0; bus.tbl_field = 0;
    bus.tbl_wdata = 0; bus.seq_go = 0; bus.seq_abort = 0;
    bus.num_swaths = 0; bus.gap_reg = 0; bus.print_active = 0;
    for (int i = 0; i < 8; i++) begin
      m_len[i] = 0; m_div[i] = 0; m_dly[i] = 0; m_adj[i] = 0;
    end

    step(); step();
    chk("reset flags", 128'(obs_flags()), 128'(0));
    chk("reset regs", obs_regs(), 128'(0));
    chk("reset index", 128'(bus.swath_index), 128'(0));
    rst = 0;

    tbl_write(0, 0, 32'd100);
    tbl_write(0, 1, 32'd4);
    tbl_write(0, 2, 32'd10);
    tbl_write(0, 3, 32'hFFFF_FFFF);
    for (int e = 1; e < 8; e++)
      for (int f = 0; f < 4; f++)
        tbl_write(e, f, $urandom);

    rows[0] = '{1, 0, 1, 500, 1, 1, 1};
    rows[1] = '{3, 20, 1, 8, 3, 3, 1};
    rows[2] = '{0, 4, 1, 5, 0, 0, 1};
    rows[3] = '{9, 0, 2, 3, 8, 8, 1};
    rows[4] = '{8, 1, 1, 1, 8, 8, 1};
    rows[5] = '{2, 0, 4, 2, 2, 2, 1};
    foreach (rows[i]) begin
      run_seq(rows[i].n, rows[i].g, rows[i].d, rows[i].r,
              -1, -1, 0, 0, 0);
      chk($sformatf("row%0d starts", i), 128'(n_start),
          128'(rows[i].e_start));
      chk($sformatf("row%0d swath_done", i), 128'(n_sdone),
          128'(rows[i].e_sdone));
      chk($sformatf("row%0d seq_done", i), 128'(n_qdone),
          128'(rows[i].e_qdone));
      if (rows[i].n >= 2)
        chk($sformatf("row%0d jet gap", i),
            128'(min_gap >= rows[i].g), 128'(1));
    end

    // write to the active entry is dropped, to a later entry accepted
    run_seq(2, 3, 2, 10, -1, 1, 0, 0, 32'hDEAD_BEEF);
    run_seq(2, 3, 2, 10, -1, 1, 1, 3, 32'h0000_1234);
    run_seq(1, 0, 1, 3, -1, -1, 0, 0, 0);
    chk("entry0 kept", 128'(bus.length_reg), 128'(100));

    // abort during RUN of swath 1 of 3
    plan(3, 5, 1, 30);
    ab = ss[1] + 1 + 5;
    run_seq(3, 5, 1, 30, ab, -1, 0, 0, 0);
    chk("abort starts", 128'(n_start), 128'(2));
    chk("abort seq_done", 128'(n_qdone), 128'(0));

    // abort and go together in IDLE
    step();
    bus.seq_go = 1; bus.seq_abort = 1; bus.num_swaths = 2;
    step();
    bus.seq_go = 0; bus.seq_abort = 0;
    chk("go+abort idle", 128'(obs_flags()), 128'(0));
    n_start = 0;
    repeat (8) begin
      step();
      n_start += int'(bus.start_pulse);
    end
    chk("go+abort no start", 128'(n_start), 128'(0));

    // reset while arming
    step();
    bus.seq_go = 1; bus.num_swaths = 1; bus.gap_reg = 0;
    step();
    bus.seq_go = 0;
    step();
    chk("arm jet", 128'(bus.jet_enable), 128'(1));
    #2 rst = 1;
    #1;
    chk("rst flags", 128'(obs_flags()), 128'(0));
    chk("rst regs", obs_regs(), 128'(0));
    for (int i = 0; i < 8; i++) begin
      m_len[i] = 0; m_div[i] = 0; m_dly[i] = 0; m_adj[i] = 0;
    end
    step(); step();
    rst = 0;
    n_start = 0;
    repeat (20) begin
      step();
      n_start += int'(bus.start_pulse) + int'(bus.jet_enable);
    end
    chk("post-rst idle", 128'(n_start), 128'(0));
    run_seq(1, 0, 1, 2, -1, -1, 0, 0, 0);

`ifdef SWATH_TIMEOUT_EN
    plan(1, 0, 1, 1);
    step();
    bus.seq_go = 1; bus.num_swaths = 1;
    for (int t = 0; t <= ss[0] + TO + 2; t++) begin
      step();
      bus.seq_go = 0; bus.print_active = 0;
      if (t == ss[0] + TO - 1)
        chk("timeout early", 128'(bus.timeout_err), 128'(0));
      if (t == ss[0] + TO)
        chk("timeout hit",
            128'({bus.timeout_err, bus.jet_enable, bus.seq_busy}),
            128'(3'b100));
    end
    bus.seq_go = 1; bus.num_swaths = 0;
    step();
    bus.seq_go = 0;
    chk("timeout clear",
        128'({bus.timeout_err, bus.seq_done}), 128'(2'b01));
`else
    step();
    bus.seq_go = 1; bus.num_swaths = 1;
    for (int t = 0; t <= 60; t++) begin
      step();
      bus.seq_go = 0; bus.print_active = 0;
      if (t == 60) begin
        chk("no timeout",
            128'({bus.timeout_err, bus.jet_enable, bus.seq_busy}),
            128'(3'b011));
        bus.seq_abort = 1;
      end
    end
    step();
    bus.seq_abort = 0;
    chk("wait abort", 128'(obs_flags()), 128'(7'b0000010));
`endif

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1)
        tbl_write($urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom);
      n = $urandom_range(0, 10);
      g = $urandom_range(0, 12);
      d = $urandom_range(1, 4);
      r = $urandom_range(1, 15);
      plan(n, g, d, r);
      ab = (done_t > 0 && $urandom_range(0, 2) == 0)
           ? $urandom_range(0, done_t - 1) : -1;
      wt = $urandom_range(0, done_t + 1);
      run_seq(n, g, d, r, ab, wt, $urandom_range(0, 7),
              $urandom_range(0, 3), $urandom);
      chk($sformatf("rand%0d starts", it), 128'(n_start),
          128'((ab < 0) ? nn : n_start));
      chk($sformatf("rand%0d seq_done", it), 128'(n_qdone),
          128'((ab < 0) ? 1 : 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
